pe_bus_requester: RTL
=====================

Name: pe_bus_requester

Overview:
- Core-side endpoint of the shared PE data bus; one instance per PE core.
- Raises a request to the output arbiter, waits for grant, then moves data over the bus:
  - load: fixed burst from main memory into a local buffer;
  - unload: fixed burst of results from the local buffer back to memory.
- Tracks its own loaded/unloaded state, toggling load then unload, so each arbiter grant always finds a matching transfer direction.
- The PE datapath reads and writes the local buffer between bursts.

Parameters:
- DATA_WIDTH, 8, bus and buffer word width
- BURST_WRITE, `OUT_ARB_FIXED_BURST_WRITE, words per load burst (memory to core); must be >=1
- BURST_READ, `OUT_ARB_FIXED_BURST_READ, words per unload burst (core to memory); must be >=1
- BUF_DEPTH, max(BURST_WRITE, BURST_READ), local buffer words
- BUF_AW, $clog2(BUF_DEPTH), buffer address width

Ports:
- w_clock  in  1  clock, all logic on posedge
- w_ready  in  1  synchronous active-low reset; w_ready=0 at posedge resets the block
- w_start_load  in  1  PE asks for a new operand load
- w_compute_done  in  1  PE results in buffer, ready to unload
- w_grant  in  1  this core's grant bit from the arbiter
- w_bus_rw  in  1  arbiter direction: 0 = write into core (load), 1 = read from core (unload)
- w_bus_valid  in  1  memory presents a load word this cycle
- w_bus_data_in  in  DATA_WIDTH  load word
- r_req  out  1  request to the arbiter
- w_bus_valid_out  out  1  core drives an unload word this cycle
- w_bus_data_out  out  DATA_WIDTH  unload word; 0 when w_bus_valid_out=0
- w_pe_addr  in  BUF_AW  PE buffer address
- w_pe_we  in  1  PE buffer write enable
- w_pe_wdata  in  DATA_WIDTH  PE write data
- w_pe_rdata  out  DATA_WIDTH  buffer[w_pe_addr], combinational
- r_loaded  out  1  buffer holds a completed load
- r_err  out  1  sticky: grant received with the wrong w_bus_rw

Behaviour:
- States: IDLE, REQ_LOAD, LOAD, LOADED, REQ_UNLOAD, UNLOAD.
- Reset (w_ready=0 at posedge, any state, including mid-burst):
  - state IDLE; r_req, r_loaded, r_err and the beat counter all go to 0.
  - Buffer contents are not cleared.
  - w_bus_valid_out=0.
- IDLE: w_start_load=1 -> REQ_LOAD; r_req=1 from the next cycle.
- REQ_LOAD:
  - w_grant=1 && w_bus_rw=0 -> LOAD with count=0.
  - w_grant=1 && w_bus_rw=1 -> r_err<=1 and stay in REQ_LOAD.
- LOAD:
  - Each cycle with w_grant=1 && w_bus_valid=1: buffer[count]<=w_bus_data_in and count++.
  - Beats without grant are ignored, so loss of grant pauses the burst.
  - On the beat where count==BURST_WRITE-1 is written -> LOADED, with r_req<=0 and r_loaded<=1 at that same edge.
- LOADED:
  - PE port writes are accepted.
  - w_compute_done=1 -> REQ_UNLOAD; r_req=1 from the next cycle.
- REQ_UNLOAD:
  - w_grant=1 && w_bus_rw=1 -> UNLOAD with count=0.
  - Wrong direction -> r_err<=1 and stay.
- UNLOAD:
  - w_bus_valid_out = w_grant (combinational); w_bus_data_out = buffer[count].
  - count++ on each granted cycle.
  - After the beat with count==BURST_READ-1 -> IDLE, with r_req<=0 and r_loaded<=0.
  - One word per granted cycle; the first word appears in the first cycle in UNLOAD.
- PE write port: active only in IDLE and LOADED; ignored during LOAD and UNLOAD.
- Buffer write-port priority in LOAD: bus. The bus wins over the PE port in LOAD; no conflict is possible elsewhere.
- Ignored inputs:
  - w_start_load outside IDLE;
  - w_compute_done outside LOADED;
  - w_bus_valid outside LOAD.
- Counter: BUF_AW+1 bits, no wrap; it is cleared on every entry to LOAD or UNLOAD.
- Request timing:
  - r_req drops in the same edge as the final beat. The arbiter therefore sees the request removed before its next arbitration.
  - r_req is never asserted in IDLE or LOADED.

Decomposition:
- parameters.vh:
  - add `OUT_REQ_DATA_WIDTH;
  - reuse `OUT_ARB_FIXED_BURST_WRITE and `OUT_ARB_FIXED_BURST_READ;
  - add state encodings `OUT_REQ_S_* (3-bit).
- One sub-module, pe_local_buffer:
  - register array, BUF_DEPTH x DATA_WIDTH;
  - one synchronous write port, muxed bus/PE by state;
  - two combinational read ports (bus, PE).
- FSM, counter and request logic stay in pe_bus_requester.

Test Plan (BURST_WRITE=4, BURST_READ=4):
- Full cycle:
  - Stimulus: reset low 2 cycles, release; pulse w_start_load; grant with rw=0; valid every cycle with data 0x11,0x22,0x33,0x44.
  - Response: r_req rises 1 cycle after start and falls with beat 4; r_loaded=1; w_pe_rdata at addr 2 = 0x33.
- Unload:
  - Stimulus: from LOADED, PE writes 0xA0..0xA3 to addr 0..3; pulse w_compute_done; grant with rw=1.
  - Response: w_bus_valid_out high 4 cycles with data 0xA0,0xA1,0xA2,0xA3; then IDLE, r_req=0, r_loaded=0.
- Grant gap:
  - Stimulus: during LOAD, drop w_grant after 2 beats for 3 cycles, with w_bus_valid held high.
  - Response: those 3 beats are not stored; the burst resumes at buffer[2]; 4 stored words total.
- Wrong direction:
  - Stimulus: in REQ_LOAD, grant with rw=1.
  - Response: r_err=1, state stays REQ_LOAD, r_req stays 1; a later rw=0 grant completes the load.
- Mid-burst reset:
  - Stimulus: w_ready=0 during UNLOAD beat 2.
  - Response: next cycle r_req=0, w_bus_valid_out=0, r_loaded=0, r_err=0; a fresh w_start_load restarts the load at count 0.
- Ignored inputs:
  - Stimulus: w_start_load during LOADED; w_compute_done during IDLE.
  - Response: no state change, r_req stays 0.

Source files
------------

// File: rtl/pe_bus_requester_pkg.sv
// ---------------------------------------------------------------------------
// pe_bus_requester_pkg
// Shared constants and types for the PE bus requester slice.
//   OUT_REQ_DATA_WIDTH        - default bus/buffer word width
//   OUT_ARB_FIXED_BURST_WRITE - words per load burst (memory -> core)
//   OUT_ARB_FIXED_BURST_READ  - words per unload burst (core -> memory)
//   out_req_state_e           - requester FSM states (3-bit encoding)
//   out_req_max()             - helper used to size the local buffer
// ---------------------------------------------------------------------------
package pe_bus_requester_pkg;

  localparam int OUT_REQ_DATA_WIDTH        = 8;
  localparam int OUT_ARB_FIXED_BURST_WRITE = 4;
  localparam int OUT_ARB_FIXED_BURST_READ  = 4;

  typedef enum logic [2:0] {
    OUT_REQ_S_IDLE       = 3'd0,
    OUT_REQ_S_REQ_LOAD   = 3'd1,
    OUT_REQ_S_LOAD       = 3'd2,
    OUT_REQ_S_LOADED     = 3'd3,
    OUT_REQ_S_REQ_UNLOAD = 3'd4,
    OUT_REQ_S_UNLOAD     = 3'd5
  } out_req_state_e;

  function automatic int out_req_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_bus_requester_if.sv
// ---------------------------------------------------------------------------
// pe_bus_requester_if
// Handshake and data signals between one PE core and the output arbiter /
// memory side of the shared PE data bus.
//   w_grant, w_bus_rw             - arbiter grant bit and transfer direction
//   w_bus_valid, w_bus_data_in    - load word presented by memory
//   r_req                         - request from the core to the arbiter
//   w_bus_valid_out, w_bus_data_out - unload word driven by the core
// Modports: master = core-side requester, slave = arbiter/memory side.
// ---------------------------------------------------------------------------
interface pe_bus_requester_if
  import pe_bus_requester_pkg::*;
#(
  parameter int DATA_WIDTH = OUT_REQ_DATA_WIDTH
) ();

  logic                  w_grant;
  logic                  w_bus_rw;
  logic                  w_bus_valid;
  logic [DATA_WIDTH-1:0] w_bus_data_in;
  logic                  r_req;
  logic                  w_bus_valid_out;
  logic [DATA_WIDTH-1:0] w_bus_data_out;

  modport master (
    input  w_grant, w_bus_rw, w_bus_valid, w_bus_data_in,
    output r_req, w_bus_valid_out, w_bus_data_out
  );

  modport slave (
    output w_grant, w_bus_rw, w_bus_valid, w_bus_data_in,
    input  r_req, w_bus_valid_out, w_bus_data_out
  );

endinterface

// File: rtl/pe_bus_requester_buffer.sv
// ---------------------------------------------------------------------------
// pe_local_buffer
// Register-array operand/result buffer of one PE core. No reset: contents
// survive a requester reset.
//   w_clock                        - clock, write on posedge
//   w_we, w_waddr, w_wdata         - single synchronous write port
//   w_bus_raddr -> w_bus_rdata     - combinational read port for unload
//   w_pe_raddr  -> w_pe_rdata      - combinational read port for the PE
// ---------------------------------------------------------------------------
module pe_local_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int BUF_AW     = $clog2(BUF_DEPTH)
) (
  input  logic                  w_clock,
  input  logic                  w_we,
  input  logic [BUF_AW-1:0]     w_waddr,
  input  logic [DATA_WIDTH-1:0] w_wdata,
  input  logic [BUF_AW-1:0]     w_bus_raddr,
  output logic [DATA_WIDTH-1:0] w_bus_rdata,
  input  logic [BUF_AW-1:0]     w_pe_raddr,
  output logic [DATA_WIDTH-1:0] w_pe_rdata
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

  // Storage write. When the depth is not a power of two the address space
  // is larger than the array, so out-of-range writes are dropped.
  always_ff @(posedge w_clock) begin
    if (w_we && (32'(w_waddr) < 32'(BUF_DEPTH))) begin
      mem[w_waddr] <= w_wdata;
    end
  end

  // Out-of-range reads return zero rather than an undefined word.
  assign w_bus_rdata = (32'(w_bus_raddr) < 32'(BUF_DEPTH)) ? mem[w_bus_raddr] : '0;
  assign w_pe_rdata  = (32'(w_pe_raddr)  < 32'(BUF_DEPTH)) ? mem[w_pe_raddr]  : '0;

endmodule

// File: rtl/pe_bus_requester.sv
// ---------------------------------------------------------------------------
// pe_bus_requester
// Core-side endpoint of the shared PE data bus. Requests the bus, performs a
// fixed load burst into the local buffer, lets the PE work on the buffer,
// then requests again and unloads a fixed burst of results.
//   w_clock, w_ready        - clock and synchronous active-low reset
//   w_start_load            - PE asks for a new operand load (IDLE only)
//   w_compute_done          - PE results ready to unload (LOADED only)
//   bus (master modport)    - arbiter grant/direction, load/unload words, r_req
//   w_pe_addr/we/wdata      - PE buffer write port (IDLE and LOADED only)
//   w_pe_rdata              - buffer[w_pe_addr], combinational
//   r_loaded                - buffer holds a completed load
//   r_err                   - sticky: grant arrived with the wrong direction
// ---------------------------------------------------------------------------
module pe_bus_requester
  import pe_bus_requester_pkg::*;
#(
  parameter int DATA_WIDTH  = OUT_REQ_DATA_WIDTH,
  parameter int BURST_WRITE = OUT_ARB_FIXED_BURST_WRITE,
  parameter int BURST_READ  = OUT_ARB_FIXED_BURST_READ,
  parameter int BUF_DEPTH   = out_req_max(BURST_WRITE, BURST_READ),
  parameter int BUF_AW      = $clog2(BUF_DEPTH)
) (
  input  logic                  w_clock,
  input  logic                  w_ready,
  input  logic                  w_start_load,
  input  logic                  w_compute_done,
  pe_bus_requester_if.master    bus,
  input  logic [BUF_AW-1:0]     w_pe_addr,
  input  logic                  w_pe_we,
  input  logic [DATA_WIDTH-1:0] w_pe_wdata,
  output logic [DATA_WIDTH-1:0] w_pe_rdata,
  output logic                  r_loaded,
  output logic                  r_err
);

  localparam int CNT_W = BUF_AW + 1;
  localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(BURST_WRITE - 1);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(BURST_READ - 1);

  out_req_state_e        state;
  logic [CNT_W-1:0]      count;
  logic                  req_q;
  logic                  load_beat;
  logic                  buf_we;
  logic [BUF_AW-1:0]     buf_waddr;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;

  assign load_beat = bus.w_grant && bus.w_bus_valid;

  // Requester FSM with registered request/status outputs. The request is
  // dropped on the same edge that commits the final beat so the arbiter
  // never sees a stale request at its next decision. Each burst restarts
  // the beat counter at zero; a pause in grant simply holds the counter.
  always_ff @(posedge w_clock) begin
    if (!w_ready) begin
      state    <= OUT_REQ_S_IDLE;
      req_q    <= 1'b0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        OUT_REQ_S_IDLE: begin
          if (w_start_load) begin
            state <= OUT_REQ_S_REQ_LOAD;
            req_q <= 1'b1;
          end
        end
        OUT_REQ_S_REQ_LOAD: begin
          if (bus.w_grant) begin
            if (!bus.w_bus_rw) begin
              state <= OUT_REQ_S_LOAD;
              count <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        OUT_REQ_S_LOAD: begin
          if (load_beat) begin
            count <= count + CNT_W'(1);
            if (count == LAST_WR) begin
              state    <= OUT_REQ_S_LOADED;
              req_q    <= 1'b0;
              r_loaded <= 1'b1;
            end
          end
        end
        OUT_REQ_S_LOADED: begin
          if (w_compute_done) begin
            state <= OUT_REQ_S_REQ_UNLOAD;
            req_q <= 1'b1;
          end
        end
        OUT_REQ_S_REQ_UNLOAD: begin
          if (bus.w_grant) begin
            if (bus.w_bus_rw) begin
              state <= OUT_REQ_S_UNLOAD;
              count <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        OUT_REQ_S_UNLOAD: begin
          if (bus.w_grant) begin
            count <= count + CNT_W'(1);
            if (count == LAST_RD) begin
              state    <= OUT_REQ_S_IDLE;
              req_q    <= 1'b0;
              r_loaded <= 1'b0;
            end
          end
        end
        default: begin
          state <= OUT_REQ_S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Buffer write-port steering: bus beats own the port during LOAD, the PE
  // owns it in IDLE and LOADED, and nobody writes in the other states.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = w_pe_addr;
    buf_wdata = w_pe_wdata;
    case (state)
      OUT_REQ_S_LOAD: begin
        buf_we    = load_beat;
        buf_waddr = count[BUF_AW-1:0];
        buf_wdata = bus.w_bus_data_in;
      end
      OUT_REQ_S_IDLE, OUT_REQ_S_LOADED: begin
        buf_we = w_pe_we;
      end
      default: begin
        buf_we = 1'b0;
      end
    endcase
  end

  pe_local_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .BUF_AW     (BUF_AW)
  ) u_buf (
    .w_clock     (w_clock),
    .w_we        (buf_we),
    .w_waddr     (buf_waddr),
    .w_wdata     (buf_wdata),
    .w_bus_raddr (count[BUF_AW-1:0]),
    .w_bus_rdata (bus_rdata),
    .w_pe_raddr  (w_pe_addr),
    .w_pe_rdata  (w_pe_rdata)
  );

  // Unload words go out in the same cycle the grant is seen, so the first
  // word appears in the first UNLOAD cycle; the data bus idles at zero.
  assign bus.r_req           = req_q;
  assign bus.w_bus_valid_out = (state == OUT_REQ_S_UNLOAD) && bus.w_grant;
  assign bus.w_bus_data_out  = bus.w_bus_valid_out ? bus_rdata : '0;

endmodule
